// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and load/store.
// Handles lane steering and load extension, and times out requests the memory never answers.

module mem_port_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  ofs,
    input  logic [31:0] wdata,
    output logic        be,
    output logic [7:0]  wbyte
);
    localparam logic [1:0] LID = 2'(LANE);

    always_comb begin
        be    = 1'b0;
        wbyte = wdata[7:0];
        case (size)
            2'b00: begin
                be    = 1'b1;
                wbyte = wdata[8*LANE +: 8];
            end
            2'b01: begin
                be    = (ofs[1] == LID[1]);
                wbyte = wdata[8*(LANE%2) +: 8];
            end
            2'b10: begin
                be    = (ofs == LID);
                wbyte = wdata[7:0];
            end
            default: ;
        endcase
    end
endmodule

module mem_port_arbiter #(
    parameter int MAX_WAIT   = 16,
    parameter int DATA_BURST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall
);
    localparam int          NUM_LANES = 4;
    localparam int          WW        = $clog2(MAX_WAIT + 1);
    localparam int          BW        = $clog2(DATA_BURST + 1);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] ofs;
    } ld_req_t;

    state_t  state, state_nxt;
    ld_req_t ld_q;
    logic [WW-1:0] wait_cnt;
    logic [BW-1:0] burst_cnt;

    logic [NUM_LANES-1:0]      lane_be;
    logic [NUM_LANES-1:0][7:0] lane_wdata;

    logic if_pend, d_pend, grant_en, d_illegal, burst_cap;
    logic take_d, take_f, bad_d, tmo;
    logic [31:0] ld_shift, ld_data;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mem_port_lane #(.LANE(i)) u_lane (
            .size  (d_size),
            .ofs   (d_addr[1:0]),
            .wdata (d_wdata),
            .be    (lane_be[i]),
            .wbyte (lane_wdata[i])
        );
    end

    assign if_pend = if_req & ~if_ack;
    assign d_pend  = (d_read | d_write) & ~d_ack;
    assign stall   = if_pend | d_pend;

    // The cycle carrying an ack is a turnaround: a data requester that keeps
    // its request held then competes against a waiting fetch on equal terms.
    assign grant_en  = (state == IDLE) & ~if_ack & ~d_ack;
    assign d_illegal = (d_size == 2'b11) | ((d_size == 2'b01) & d_addr[0]) |
                       ((d_size == 2'b00) & (|d_addr[1:0]));
    assign burst_cap = (burst_cnt == BW'(DATA_BURST)) & if_pend;
    assign take_d    = grant_en & d_pend & ~d_illegal & ~burst_cap;
    assign take_f    = grant_en & if_pend & ~take_d;
    assign bad_d     = grant_en & d_pend & d_illegal;
    assign tmo       = (wait_cnt == WW'(MAX_WAIT - 1));

    always_comb begin
        ld_shift = mem_rdata >> {ld_q.ofs, 3'b000};
        ld_data  = ld_shift;
        case (ld_q.size)
            2'b01:   ld_data = {{16{ld_q.sgn & ld_shift[15]}}, ld_shift[15:0]};
            2'b10:   ld_data = {{24{ld_q.sgn & ld_shift[7]}}, ld_shift[7:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take_d)      state_nxt = DATA;
                else if (take_f) state_nxt = FETCH;
            end
            default: begin
                if (mem_ready || tmo) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            ld_q      <= '0;
            if_rdata  <= '0;
            if_ack    <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            state    <= state_nxt;
            if_ack   <= 1'b0;
            if_rdata <= '0;
            d_ack    <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
            case (state)
                IDLE: begin
                    if (take_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_write;
                        mem_addr  <= d_addr & ~32'h3;
                        mem_be    <= lane_be;
                        mem_wdata <= lane_wdata;
                        ld_q      <= '{we: d_write, size: d_size, sgn: d_signed, ofs: d_addr[1:0]};
                        wait_cnt  <= '0;
                        if (burst_cnt != BW'(DATA_BURST)) burst_cnt <= burst_cnt + 1'b1;
                    end else if (take_f) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr & ~32'h3;
                        mem_be    <= 4'b1111;
                        mem_wdata <= '0;
                        wait_cnt  <= '0;
                        burst_cnt <= '0;
                    end else if (!if_pend) begin
                        burst_cnt <= '0;
                    end
                    if (bad_d) begin
                        d_ack <= 1'b1;
                        d_err <= 1'b1;
                    end
                end
                default: begin
                    // A ready arriving on the last allowed cycle still completes normally.
                    if (mem_ready || tmo) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        if (state == FETCH) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_ready ? mem_rdata : NOP;
                        end else begin
                            d_ack   <= 1'b1;
                            d_err   <= ~mem_ready;
                            d_rdata <= (mem_ready && !ld_q.we) ? ld_data : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected memory accesses and acks are
// queued as stimulus is driven and compared when the DUT produces them.

module tb_mem_port_arbiter;
    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_read, d_write;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        d_signed, d_ack, d_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        stall;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } dexp_t;

    mexp_t       exp_mem[$];
    dexp_t       exp_d[$];
    logic [31:0] exp_f[$];

    int          n_chk = 0;
    int          n_pass = 0;
    int          ready_delay = 0;
    logic [31:0] mem_val = '0;

    mem_port_arbiter #(.MAX_WAIT(16), .DATA_BURST(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_size    (d_size),
        .d_signed  (d_signed),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall     (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Memory model: answers after ready_delay cycles of mem_req.
    initial begin
        int cyc;
        cyc = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_DEAD;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mem_ready = (cyc >= ready_delay);
                mem_rdata = mem_ready ? mem_val : 32'hDEAD_DEAD;
                cyc++;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_DEAD;
                cyc = 0;
            end
        end
    end

    // Monitor: pops expectations as the DUT issues accesses and acks.
    initial begin
        logic        prev;
        mexp_t       m;
        dexp_t       d;
        logic [31:0] f;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev) begin
                if (exp_mem.size() == 0) chk("unexpected_mem_req", 1, 0);
                else begin
                    m = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_we", mem_we, m.we);
                    chk("mem_be", mem_be, m.be);
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end
            prev = mem_req;
            if (d_ack) begin
                if (exp_d.size() == 0) chk("unexpected_d_ack", 1, 0);
                else begin
                    d = exp_d.pop_front();
                    chk("d_rdata", d_rdata, d.rdata);
                    chk("d_err", d_err, d.err);
                end
            end
            if (if_ack) begin
                if (exp_f.size() == 0) chk("unexpected_if_ack", 1, 0);
                else begin
                    f = exp_f.pop_front();
                    chk("if_rdata", if_rdata, f);
                end
            end
        end
    end

    task automatic data_op(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                           input logic [31:0] wd, input logic [31:0] mval, input int dly,
                           input logic use_mem, input logic [3:0] ebe, input logic [31:0] ewd,
                           input logic [31:0] erd, input logic eerr,
                           output int lat, output int rc);
        mexp_t m;
        dexp_t d;
        bit    done;
        if (use_mem) begin
            m.we = wr; m.addr = {addr[31:2], 2'b00}; m.be = ebe; m.wdata = ewd;
            exp_mem.push_back(m);
        end
        d.rdata = erd; d.err = eerr;
        exp_d.push_back(d);
        mem_val = mval;
        ready_delay = dly;
        @(negedge clk);
        d_read = rd; d_write = wr; d_addr = addr; d_size = size; d_signed = sgn; d_wdata = wd;
        lat = 0; rc = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (mem_req) rc++;
            if (lat == 1 && !d_ack) chk({tag, "_stall"}, stall, 1);
            if (d_ack) begin
                chk({tag, "_stall_at_ack"}, stall, 0);
                done = 1;
            end
        end
        if (!done) chk({tag, "_ack_timeout"}, 0, 1);
        d_read = 0; d_write = 0;
    endtask

    task automatic fetch_op(input string tag, input logic [31:0] addr, input logic [31:0] mval,
                            input int dly, input logic [31:0] erd, output int lat, output int rc);
        mexp_t m;
        bit    done;
        m.we = 0; m.addr = addr; m.be = 4'b1111; m.wdata = '0;
        exp_mem.push_back(m);
        exp_f.push_back(erd);
        mem_val = mval;
        ready_delay = dly;
        @(negedge clk);
        if_req = 1; if_addr = addr;
        lat = 0; rc = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (mem_req) rc++;
            if (if_ack) done = 1;
        end
        if (!done) chk({tag, "_ack_timeout"}, 0, 1);
        if_req = 0;
    endtask

    initial begin
        int    lat, rc, nd, nf;
        bit    seen;
        mexp_t m;
        dexp_t d;
        reset = 0;
        if_req = 0; if_addr = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_size = '0; d_signed = 0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_d_ack", d_ack, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_stall", stall, 0);
        reset = 1;

        data_op("lb_s", 1, 0, 32'h103, 2'b10, 1, 32'h0, 32'h80FF_0000, 0, 1, 4'b1000, 0, 32'hFFFF_FF80, 0, lat, rc);
        chk("lb_s_latency", lat, 2);
        data_op("sh", 0, 1, 32'h22, 2'b01, 0, 32'h1234_ABCD, 0, 0, 1, 4'b1100, 32'hABCD_ABCD, 0, 0, lat, rc);
        data_op("lhu", 1, 0, 32'h22, 2'b01, 0, 0, 32'h8765_4321, 0, 1, 4'b1100, 0, 32'h0000_8765, 0, lat, rc);
        data_op("lh_s", 1, 0, 32'h22, 2'b01, 1, 0, 32'h8765_4321, 0, 1, 4'b1100, 0, 32'hFFFF_8765, 0, lat, rc);
        data_op("lbu", 1, 0, 32'h101, 2'b10, 0, 0, 32'h1234_5678, 0, 1, 4'b0010, 0, 32'h0000_0056, 0, lat, rc);
        data_op("lw_dly", 1, 0, 32'h200, 2'b00, 1, 0, 32'hCAFE_F00D, 3, 1, 4'b1111, 0, 32'hCAFE_F00D, 0, lat, rc);
        chk("lw_dly_latency", lat, 5);
        data_op("sb", 0, 1, 32'h41, 2'b10, 0, 32'hDEAD_BEEF, 0, 0, 1, 4'b0010, 32'hEFEF_EFEF, 0, 0, lat, rc);
        data_op("sw", 0, 1, 32'h44, 2'b00, 0, 32'hDEAD_BEEF, 0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 0, 0, lat, rc);
        data_op("rw_both", 1, 1, 32'h20, 2'b01, 0, 32'h5555_AAAA, 32'h1111_1111, 0, 1, 4'b0011, 32'hAAAA_AAAA, 0, 0, lat, rc);

        data_op("lw_mis", 1, 0, 32'h102, 2'b00, 0, 0, 32'h1, 0, 0, 4'b0, 0, 0, 1, lat, rc);
        chk("lw_mis_latency", lat, 1);
        chk("lw_mis_no_mem", rc, 0);
        data_op("lh_mis", 1, 0, 32'h101, 2'b01, 0, 0, 32'h1, 0, 0, 4'b0, 0, 0, 1, lat, rc);
        data_op("sh_mis", 0, 1, 32'h23, 2'b01, 0, 32'h1, 0, 0, 0, 4'b0, 0, 0, 1, lat, rc);
        data_op("size11", 1, 0, 32'h100, 2'b11, 0, 0, 32'h1, 0, 0, 4'b0, 0, 0, 1, lat, rc);
        chk("size11_no_mem", rc, 0);

        fetch_op("fetch", 32'h1000, 32'h0050_0093, 0, 32'h0050_0093, lat, rc);
        chk("fetch_latency", lat, 2);

        // Held fetch and load requests: expect D,D,F,D,D,F.
        mem_val = 32'h1122_3344;
        ready_delay = 0;
        for (int i = 0; i < 6; i++) begin
            m.we = 0; m.be = 4'b1111; m.wdata = '0;
            m.addr = (i % 3 == 2) ? 32'h1000 : 32'h200;
            exp_mem.push_back(m);
        end
        d.rdata = 32'h1122_3344; d.err = 0;
        repeat (4) exp_d.push_back(d);
        repeat (2) exp_f.push_back(32'h1122_3344);
        @(negedge clk);
        d_read = 1; d_addr = 32'h200; d_size = 2'b00; d_signed = 0;
        if_req = 1; if_addr = 32'h1000;
        nd = 0; nf = 0;
        for (int i = 0; i < 80 && !(nd == 4 && nf == 2); i++) begin
            @(negedge clk);
            if (d_ack) nd++;
            if (if_ack) nf++;
            if (nd == 4) d_read = 0;
            if (nf == 2) if_req = 0;
        end
        d_read = 0; if_req = 0;
        chk("arb_data_grants", nd, 4);
        chk("arb_fetch_grants", nf, 2);

        data_op("lw_tmo", 1, 0, 32'h300, 2'b00, 0, 0, 32'h5A5A_5A5A, 100, 1, 4'b1111, 0, 0, 1, lat, rc);
        chk("lw_tmo_req_cycles", rc, 16);
        chk("lw_tmo_latency", lat, 17);
        data_op("lw_last", 1, 0, 32'h300, 2'b00, 0, 0, 32'h5A5A_5A5A, 15, 1, 4'b1111, 0, 32'h5A5A_5A5A, 0, lat, rc);
        chk("lw_last_req_cycles", rc, 16);
        data_op("lw_tmo16", 1, 0, 32'h300, 2'b00, 0, 0, 32'h5A5A_5A5A, 16, 1, 4'b1111, 0, 0, 1, lat, rc);
        fetch_op("fetch_tmo", 32'h2000, 32'h1234_5678, 100, 32'h0000_0013, lat, rc);
        chk("fetch_tmo_req_cycles", rc, 16);

        // Reset in the middle of a data access: no ack may follow.
        m.we = 0; m.addr = 32'h300; m.be = 4'b1111; m.wdata = '0;
        exp_mem.push_back(m);
        ready_delay = 100;
        @(negedge clk);
        d_read = 1; d_addr = 32'h300; d_size = 2'b00; d_signed = 0;
        repeat (3) @(negedge clk);
        chk("midrst_req_before", mem_req, 1);
        reset = 0; d_read = 0;
        @(negedge clk);
        chk("midrst_req", mem_req, 0);
        chk("midrst_ack", d_ack, 0);
        reset = 1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (d_ack || mem_req) seen = 1;
        end
        chk("midrst_quiet", seen, 0);
        fetch_op("fetch_after_rst", 32'h3000, 32'h0000_0033, 0, 32'h0000_0033, lat, rc);
        chk("fetch_after_rst_latency", lat, 2);

        repeat (2) @(negedge clk);
        chk("sb_drained", exp_mem.size() + exp_d.size() + exp_f.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
